// File: rtl/fxp_nn_pkg.sv
// Shared fixed-point types, state encoding and
// saturating add for the perceptron datapath.
package fxp_nn_pkg;

  localparam int FXP_W    = 16;
  localparam int FXP_FRAC = 12;

  typedef logic signed [FXP_W-1:0] fxp_t;

  localparam fxp_t FXP_ONE = fxp_t'(1 << FXP_FRAC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_UPDATE,
    S_EPOCH_END,
    S_DONE,
    S_IMAC,
    S_IRES
  } perc_state_t;

  // Clamp a + b to a signed w-bit range (w <= 31).
  function automatic logic signed [31:0] sat_add(
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input int                 w
  );
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = 33'(a) + 33'(b);
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (s > hi) begin
      s = hi;
    end else if (s < lo) begin
      s = lo;
    end
    return s[31:0];
  endfunction

endpackage

// File: rtl/fxp_perceptron_trainer_mac.sv
// Serial multiply-accumulate plus step function,
// shared by the training and inference paths.
module fxp_mac_step #(
  parameter int W    = 16,
  parameter int FRAC = 12,
  parameter int N_IN = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                acc_en,
  input  logic signed [W-1:0] w,
  input  logic signed [W-1:0] x,
  output logic                y
);

  localparam int AW = W + FRAC + $clog2(N_IN + 1);
  localparam int PW = 2 * W;

  logic signed [AW-1:0] acc;
  logic signed [PW-1:0] prod;

  assign prod = (PW'(w) * PW'(x)) >>> FRAC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (load) begin
      acc <= AW'(w);
    end else if (acc_en) begin
      acc <= acc + AW'(prod);
    end
  end

  // Zero counts as non-negative.
  assign y = ~acc[AW-1];

endmodule

// File: rtl/fxp_perceptron_trainer.sv
// Fixed-point perceptron with on-chip training
// and single-vector inference.
module fxp_perceptron_trainer
  import fxp_nn_pkg::*;
#(
  parameter int N_IN       = 2,
  parameter int W          = 16,
  parameter int FRAC       = 12,
  parameter int N_SAMPLES  = 4,
  parameter int MAX_EPOCHS = 32,
  parameter int LR_SHIFT   = 1,
  localparam int SW = (N_SAMPLES > 1) ?
                      $clog2(N_SAMPLES) : 1,
  localparam int EW = $clog2(MAX_EPOCHS + 1),
  localparam int XW = N_IN * W,
  localparam int WW = (N_IN + 1) * W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_en,
  input  logic [SW-1:0] ld_addr,
  input  logic [XW-1:0] ld_x,
  input  logic          ld_d,
  input  logic          w_init_en,
  input  logic [WW-1:0] w_init,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          converged,
  output logic [EW-1:0] epochs_out,
  output logic [WW-1:0] weights,
  input  logic          infer_valid,
  output logic          infer_ready,
  input  logic [XW-1:0] infer_x,
  output logic          infer_y_valid,
  output logic          infer_y
);

  localparam int KW = $clog2(N_IN + 2);
  localparam logic signed [31:0] ONE_LR =
    (32'sd1 <<< FRAC) >>> LR_SHIFT;

  perc_state_t state, state_n;

  logic signed [W-1:0] wt     [N_IN+1];
  logic signed [W-1:0] wt_upd [N_IN+1];
  logic [XW:0]         mem    [N_SAMPLES];
  logic [XW-1:0]       ix;
  logic [SW-1:0]       sidx;
  logic [KW-1:0]       k;
  logic                err;

  logic [XW-1:0]       x_cur;
  logic [XW-1:0]       x_src;
  logic                d_cur;
  logic signed [W-1:0] w_sel;
  logic signed [W-1:0] x_sel;
  logic                mac_load;
  logic                mac_acc;
  logic                y;
  logic                last_k;
  logic                last_s;
  logic                up;
  logic                dn;
  logic                take_w;
  logic                take_ld;
  logic                take_st;
  logic                take_inf;

  assign x_cur  = mem[sidx][XW-1:0];
  assign d_cur  = mem[sidx][XW];
  assign x_src  = (state == S_IMAC) ? ix : x_cur;
  assign last_k = (k == KW'(N_IN));
  assign last_s = (sidx == SW'(N_SAMPLES - 1));
  assign up     = d_cur & ~y;
  assign dn     = ~d_cur & y;

  // Fixed request priority while idle.
  assign take_w   = w_init_en;
  assign take_ld  = !w_init_en && ld_en;
  assign take_st  = !w_init_en && !ld_en && start;
  assign take_inf = !w_init_en && !ld_en &&
                    !start && infer_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (take_st) begin
          state_n = S_MAC;
        end else if (take_inf) begin
          state_n = S_IMAC;
        end
      end
      S_MAC: begin
        if (last_k) state_n = S_UPDATE;
      end
      S_UPDATE: begin
        state_n = last_s ? S_EPOCH_END : S_MAC;
      end
      S_EPOCH_END: begin
        if (!err ||
            epochs_out == EW'(MAX_EPOCHS - 1)) begin
          state_n = S_DONE;
        end else begin
          state_n = S_MAC;
        end
      end
      S_DONE: state_n = S_IDLE;
      S_IMAC: begin
        if (last_k) state_n = S_IRES;
      end
      S_IRES: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state == S_MAC) ||
                    (state == S_UPDATE) ||
                    (state == S_EPOCH_END);
    done          = (state == S_DONE);
    infer_ready   = (state == S_IDLE);
    infer_y_valid = (state == S_IRES);
    infer_y       = (state == S_IRES) && y;
    mac_load      = ((state == S_MAC) ||
                     (state == S_IMAC)) && (k == '0);
    mac_acc       = ((state == S_MAC) ||
                     (state == S_IMAC)) && (k != '0);
  end

  always_comb begin
    w_sel = wt[0];
    x_sel = '0;
    for (int i = 1; i <= N_IN; i++) begin
      if (k == KW'(i)) begin
        w_sel = wt[i];
        x_sel = x_src[(i-1)*W +: W];
      end
    end
  end

  // Error is +1 (up) or -1 (dn); all terms use pre-update weights.
  always_comb begin
    for (int i = 0; i <= N_IN; i++) begin
      wt_upd[i] = wt[i];
    end
    if (up) begin
      wt_upd[0] = W'(sat_add(32'(wt[0]), ONE_LR, W));
    end else if (dn) begin
      wt_upd[0] = W'(sat_add(32'(wt[0]), -ONE_LR, W));
    end
    for (int i = 1; i <= N_IN; i++) begin
      if (up) begin
        wt_upd[i] = W'(sat_add(32'(wt[i]),
          32'($signed(x_cur[(i-1)*W +: W])) >>> LR_SHIFT, W));
      end else if (dn) begin
        wt_upd[i] = W'(sat_add(32'(wt[i]),
          -(32'($signed(x_cur[(i-1)*W +: W])) >>> LR_SHIFT), W));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= N_IN; i++) wt[i] <= '0;
      for (int s = 0; s < N_SAMPLES; s++) mem[s] <= '0;
      ix         <= '0;
      sidx       <= '0;
      k          <= '0;
      err        <= 1'b0;
      converged  <= 1'b0;
      epochs_out <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          unique case (1'b1)
            take_w: begin
              for (int i = 0; i <= N_IN; i++) begin
                wt[i] <= w_init[i*W +: W];
              end
            end
            take_ld: mem[ld_addr] <= {ld_d, ld_x};
            take_st: begin
              sidx       <= '0;
              k          <= '0;
              err        <= 1'b0;
              converged  <= 1'b0;
              epochs_out <= '0;
            end
            take_inf: begin
              ix <= infer_x;
              k  <= '0;
            end
            default: ;
          endcase
        end
        S_MAC, S_IMAC: begin
          k <= last_k ? '0 : k + KW'(1);
        end
        S_UPDATE: begin
          if (up || dn) begin
            for (int i = 0; i <= N_IN; i++) begin
              wt[i] <= wt_upd[i];
            end
            err <= 1'b1;
          end
          sidx <= last_s ? '0 : sidx + SW'(1);
        end
        S_EPOCH_END: begin
          epochs_out <= epochs_out + EW'(1);
          converged  <= !err;
          err        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    weights = '0;
    for (int i = 0; i <= N_IN; i++) begin
      weights[i*W +: W] = wt[i];
    end
  end

  fxp_mac_step #(
    .W    (W),
    .FRAC (FRAC),
    .N_IN (N_IN)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (mac_load),
    .acc_en (mac_acc),
    .w      (w_sel),
    .x      (x_sel),
    .y      (y)
  );

endmodule

// File: tb/tb_fxp_perceptron_trainer.sv
// Scoreboard bench for fxp_perceptron_trainer with
// a plain-arithmetic perceptron reference model.
module tb_fxp_perceptron_trainer;

  localparam int N_IN = 2;
  localparam int W    = 16;
  localparam int FRAC = 12;
  localparam int NS   = 4;
  localparam int ME   = 32;
  localparam int LR   = 1;
  localparam int SW   = 2;
  localparam int EW   = 6;
  localparam int XW   = N_IN * W;
  localparam int WW   = (N_IN + 1) * W;
  localparam int EPOCH_CYC = NS * (N_IN + 2) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ld_en = 1'b0;
  logic [SW-1:0] ld_addr = '0;
  logic [XW-1:0] ld_x = '0;
  logic          ld_d = 1'b0;
  logic          w_init_en = 1'b0;
  logic [WW-1:0] w_init = '0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic          converged;
  logic [EW-1:0] epochs_out;
  logic [WW-1:0] weights;
  logic          infer_valid = 1'b0;
  logic          infer_ready;
  logic [XW-1:0] infer_x = '0;
  logic          infer_y_valid;
  logic          infer_y;

  fxp_perceptron_trainer #(
    .N_IN(N_IN), .W(W), .FRAC(FRAC),
    .N_SAMPLES(NS), .MAX_EPOCHS(ME),
    .LR_SHIFT(LR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_x(ld_x), .ld_d(ld_d),
    .w_init_en(w_init_en), .w_init(w_init),
    .start(start), .busy(busy), .done(done),
    .converged(converged),
    .epochs_out(epochs_out), .weights(weights),
    .infer_valid(infer_valid),
    .infer_ready(infer_ready),
    .infer_x(infer_x),
    .infer_y_valid(infer_y_valid),
    .infer_y(infer_y)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit            is_train;
    bit            y;
    bit            conv;
    int            ep;
    logic [WW-1:0] w;
    longint        t0;
    int            lat;
  } exp_t;

  exp_t sbq[$];

  // Reference model state
  longint mw[N_IN+1];
  longint mx[NS][N_IN];
  bit     md[NS];

  task automatic chk(input string name,
                     input longint act,
                     input longint expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, expv);
    end
  endtask

  function automatic longint sat(input longint v);
    longint hi, lo;
    hi = (longint'(1) <<< (W - 1)) - 1;
    lo = -(longint'(1) <<< (W - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic bit m_step(input longint xv[N_IN]);
    longint acc;
    acc = mw[0];
    for (int i = 0; i < N_IN; i++)
      acc += (mw[i+1] * xv[i]) >>> FRAC;
    return acc >= 0;
  endfunction

  function automatic void m_train(output bit conv,
                                  output int ep);
    bit err;
    bit y;
    longint sg;
    conv = 0;
    ep = 0;
    for (int e = 1; e <= ME; e++) begin
      err = 0;
      ep = e;
      for (int s = 0; s < NS; s++) begin
        y = m_step(mx[s]);
        if (y != md[s]) begin
          sg = md[s] ? 1 : -1;
          mw[0] = sat(mw[0] + sg *
            ((longint'(1) <<< FRAC) >>> LR));
          for (int i = 0; i < N_IN; i++)
            mw[i+1] = sat(mw[i+1] + sg * (mx[s][i] >>> LR));
          err = 1;
        end
      end
      if (!err) begin
        conv = 1;
        break;
      end
    end
  endfunction

  function automatic logic [WW-1:0] m_wpack();
    logic [WW-1:0] p;
    p = '0;
    for (int i = 0; i <= N_IN; i++)
      p[i*W +: W] = mw[i][W-1:0];
    return p;
  endfunction

  function automatic logic [XW-1:0] rnd_x();
    logic [XW-1:0] r;
    for (int i = 0; i < N_IN; i++)
      r[i*W +: W] = W'($urandom);
    return r;
  endfunction

  // Monitor: pops one expectation per output event.
  exp_t me;
  always @(negedge clk) begin
    if (rst_n && (done || infer_y_valid)) begin
      if (sbq.size() == 0) begin
        chk("unexpected_output",
            longint'({done, infer_y_valid}), 0);
      end else begin
        me = sbq.pop_front();
        chk("out_kind", longint'(done),
            longint'(me.is_train));
        chk("latency", cyc - me.t0, longint'(me.lat));
        if (me.is_train) begin
          chk("converged", longint'(converged),
              longint'(me.conv));
          chk("epochs_out", longint'(epochs_out),
              longint'(me.ep));
          chk("weights", longint'(weights),
              longint'(me.w));
          chk("busy_at_done", longint'(busy), 0);
        end else begin
          chk("infer_y", longint'(infer_y),
              longint'(me.y));
        end
      end
    end
  end

  task automatic do_winit(input logic [WW-1:0] v);
    w_init_en = 1'b1;
    w_init = v;
    for (int i = 0; i <= N_IN; i++)
      mw[i] = longint'($signed(v[i*W +: W]));
    @(negedge clk);
    w_init_en = 1'b0;
  endtask

  task automatic do_load(input int a,
                         input logic [XW-1:0] x,
                         input bit d);
    ld_en = 1'b1;
    ld_addr = SW'(a);
    ld_x = x;
    ld_d = d;
    for (int i = 0; i < N_IN; i++)
      mx[a][i] = longint'($signed(x[i*W +: W]));
    md[a] = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic issue_start();
    exp_t e;
    bit c;
    int ep;
    m_train(c, ep);
    e.is_train = 1;
    e.y = 0;
    e.conv = c;
    e.ep = ep;
    e.w = m_wpack();
    e.t0 = cyc;
    e.lat = ep * EPOCH_CYC + 1;
    sbq.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", longint'(busy), 1);
  endtask

  task automatic issue_infer(input logic [XW-1:0] x);
    exp_t e;
    longint xa[N_IN];
    for (int i = 0; i < N_IN; i++)
      xa[i] = longint'($signed(x[i*W +: W]));
    e.is_train = 0;
    e.y = m_step(xa);
    e.conv = 0;
    e.ep = 0;
    e.w = '0;
    e.t0 = cyc;
    e.lat = N_IN + 2;
    sbq.push_back(e);
    infer_valid = 1'b1;
    infer_x = x;
    @(negedge clk);
    infer_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: %0d outputs pending after %0d cycles",
               sbq.size(), lim);
      sbq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i <= N_IN; i++) mw[i] = 0;
    for (int s = 0; s < NS; s++) begin
      md[s] = 0;
      for (int i = 0; i < N_IN; i++) mx[s][i] = 0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_ready", longint'(infer_ready), 1);
    chk("rst_weights", longint'(weights), 0);
    chk("rst_epochs", longint'(epochs_out), 0);
    chk("rst_conv", longint'(converged), 0);

    // OR training from zero weights
    do_load(0, {16'h0000, 16'h0000}, 0);
    do_load(1, {16'h0000, 16'h1000}, 1);
    do_load(2, {16'h1000, 16'h0000}, 1);
    do_load(3, {16'h1000, 16'h1000}, 1);
    issue_start();
    wait_idle(ME * EPOCH_CYC + 50);
    chk("or_weights", longint'(weights),
        48'h0800_0800_F800);
    chk("or_epochs", longint'(epochs_out), 4);
    chk("or_conv", longint'(converged), 1);

    // AND inference
    do_winit({16'h0800, 16'h1000, 16'hE800});
    issue_infer({16'h0000, 16'h0000});
    wait_idle(20);
    issue_infer({16'h0000, 16'h1000});
    wait_idle(20);
    issue_infer({16'h1000, 16'h0000});
    wait_idle(20);
    issue_infer({16'h1000, 16'h1000});
    wait_idle(20);
    chk("and_w_kept", longint'(weights),
        48'h0800_1000_E800);

    // XOR never converges
    do_winit('0);
    do_load(3, {16'h1000, 16'h1000}, 0);
    issue_start();
    wait_idle(ME * EPOCH_CYC + 50);
    chk("xor_epochs", longint'(epochs_out), ME);
    chk("xor_conv", longint'(converged), 0);

    // start and ld_en together: load only
    start = 1'b1;
    ld_en = 1'b1;
    ld_addr = 2'd3;
    ld_x = {16'h1000, 16'h1000};
    ld_d = 1'b1;
    md[3] = 1;
    @(negedge clk);
    start = 1'b0;
    ld_en = 1'b0;
    chk("collide_busy", longint'(busy), 0);
    chk("collide_ready", longint'(infer_ready), 1);

    // w_init_en and ld_en together: weights only
    w_init_en = 1'b1;
    w_init = '0;
    ld_en = 1'b1;
    ld_addr = 2'd0;
    ld_x = {16'h2000, 16'h2000};
    ld_d = 1'b1;
    for (int i = 0; i <= N_IN; i++) mw[i] = 0;
    @(negedge clk);
    w_init_en = 1'b0;
    ld_en = 1'b0;
    chk("winit_wins", longint'(weights), 0);

    // requests while busy are ignored
    issue_start();
    repeat (10) @(negedge clk);
    start = 1'b1;
    ld_en = 1'b1;
    ld_addr = 2'd0;
    ld_x = {16'h3000, 16'h3000};
    ld_d = 1'b1;
    w_init_en = 1'b1;
    w_init = {16'h1234, 16'h5678, 16'h0ABC};
    infer_valid = 1'b1;
    infer_x = {16'h1000, 16'h1000};
    chk("busy_ready_low", longint'(infer_ready), 0);
    chk("busy_high", longint'(busy), 1);
    @(negedge clk);
    start = 1'b0;
    ld_en = 1'b0;
    w_init_en = 1'b0;
    infer_valid = 1'b0;
    wait_idle(ME * EPOCH_CYC + 50);
    chk("busy_ign_weights", longint'(weights),
        48'h0800_0800_F800);

    // reset during epoch 2
    do_winit('0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (EPOCH_CYC + 5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_weights", longint'(weights), 0);
    chk("mid_rst_epochs", longint'(epochs_out), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i <= N_IN; i++) mw[i] = 0;
    for (int s = 0; s < NS; s++) begin
      md[s] = 0;
      for (int i = 0; i < N_IN; i++) mx[s][i] = 0;
    end
    repeat (100) @(negedge clk);
    chk("post_rst_ready", longint'(infer_ready), 1);
    // cleared sample memory is what gets trained on
    issue_start();
    wait_idle(ME * EPOCH_CYC + 50);

    // saturation of w1
    do_winit({16'h8000, 16'h7F00, 16'h0000});
    for (int s = 0; s < NS; s++)
      do_load(s, {16'h7000, 16'h7000}, 1);
    issue_start();
    wait_idle(ME * EPOCH_CYC + 50);
    chk("sat_w1", longint'(weights[2*W-1:W]), 16'h7FFF);

    // randomized training and inference
    for (int r = 0; r < 6; r++) begin
      do_winit(WW'({$urandom, $urandom}));
      for (int s = 0; s < NS; s++)
        do_load(s, rnd_x(), 1'($urandom));
      issue_start();
      wait_idle(ME * EPOCH_CYC + 50);
      for (int j = 0; j < 4; j++) begin
        issue_infer(rnd_x());
        wait_idle(20);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
